// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with registered read data, level flags and error pulses
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] indata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] outdata,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic vld_q, vld_d, ovf_q, ovf_d, unf_q, unf_d;
  logic wa, ra;
  assign full = cnt_q == FULL_C;
  assign empty = cnt_q == '0;
  assign almost_full = cnt_q >= AF_C;
  assign almost_empty = cnt_q <= AE_C;
  assign count = cnt_q;
  assign outdata = out_q;
  assign out_valid = vld_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  // acceptance and next state; a write into a full FIFO is allowed only when a read frees a slot
  always_comb begin
    ra = rd_en & ~empty;
    wa = wr_en & (~full | ra);
    wp_d = wa ? wp_q + 1'b1 : wp_q;
    rp_d = ra ? rp_q + 1'b1 : rp_q;
    cnt_d = (wa & ~ra) ? cnt_q + 1'b1 : (ra & ~wa) ? cnt_q - 1'b1 : cnt_q;
    out_d = ra ? mem_q[rp_q] : out_q;
    vld_d = ra;
    ovf_d = wr_en & ~wa;
    unf_d = rd_en & ~ra;
  end
  // storage array is never reset; contents are unreachable after reset anyway
  always_ff @(posedge clk) begin
    if (wa && !rst) mem_q[wp_q] <= indata;
  end
  // control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized scoreboard bench for sync_fifo against a queue-based reference model
module tb_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFL = DEPTH - 2;
  localparam int AEL = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [WIDTH-1:0] indata = '0;
  logic [WIDTH-1:0] outdata;
  logic out_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [$clog2(DEPTH):0] count;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit vld;
    int od;
  } st_t;
  st_t st_q[$];
  int data_q[$];
  int model[$];
  int exp_out = 0;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .indata(indata), .rd_en(rd_en),
    .outdata(outdata), .out_valid(out_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the reference model advances on the same edge and queues its expectations
  task automatic step(input bit w, input bit r, input int d, input bit rs = 1'b0);
    st_t e;
    bit wa, ra;
    wr_en = w;
    rd_en = r;
    indata = d[WIDTH-1:0];
    rst = rs;
    @(posedge clk);
    if (rs) begin
      model.delete();
      exp_out = 0;
      e.ovf = 0;
      e.unf = 0;
      e.vld = 0;
    end else begin
      ra = r && model.size() > 0;
      wa = w && (model.size() < DEPTH || ra);
      if (ra) begin
        exp_out = model.pop_front();
        data_q.push_back(exp_out);
      end
      if (wa) model.push_back(d & ((1 << WIDTH) - 1));
      e.ovf = w && !wa;
      e.unf = r && !ra;
      e.vld = ra;
    end
    e.cnt = model.size();
    e.od = exp_out;
    st_q.push_back(e);
    @(negedge clk);
  endtask
  // monitor: status checked every cycle, read data popped whenever the DUT presents it
  always @(negedge clk) begin
    st_t e;
    int d;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      chk("count", 32'(count), e.cnt);
      chk("full", 32'(full), 32'(e.cnt == DEPTH));
      chk("empty", 32'(empty), 32'(e.cnt == 0));
      chk("almost_full", 32'(almost_full), 32'(e.cnt >= AFL));
      chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= AEL));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("underflow", 32'(underflow), 32'(e.unf));
      chk("out_valid", 32'(out_valid), 32'(e.vld));
      chk("outdata_hold", 32'(outdata), e.od);
    end
    if (out_valid === 1'b1) begin
      if (data_q.size() == 0) chk("spurious_read", 32'd1, 32'd0);
      else begin
        d = data_q.pop_front();
        chk("read_order", 32'(outdata), d);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, i);
    step(1, 0, 'hAA);
    step(0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 'h5C);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 'h80 + i);
    for (int i = 0; i < 40; i++) step(1, 1, i);
    for (int i = 0; i < DEPTH - 5; i++) step(1, 0, 'hC0 + i);
    step(1, 1, 'hEE);
    step(1, 1, 'hEF);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 'h10 + i);
    step(1, 1, 'h99, 1);
    step(1, 0, 'h33);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      int wp = (i / 250) % 2 == 0 ? 70 : 35;
      step($urandom_range(99) < wp, $urandom_range(99) < 100 - wp, int'($urandom_range(255)),
           $urandom_range(999) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0);
    step(0, 0, 0);
    chk("scoreboard_drained", data_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
